// File: rtl/reqrsp_pkg.sv
// Shared reqrsp definitions: payload field widths, request/response channel
// structs and a small width helper used by the mux and its route FIFO.
//
// Handshake rule used everywhere in this slice: a beat transfers on a rising
// clock edge where valid and ready are both high. Once valid is raised, the
// sender holds valid and payload stable until the transfer. Ready may depend
// combinationally on valid, but valid never depends on ready.
package reqrsp_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AMO_W  = 4;
  localparam int unsigned SIZE_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [AMO_W-1:0]  amo;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [SIZE_W-1:0] size;
  } req_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              error;
  } rsp_chan_t;

  typedef struct packed {
    logic      q_valid;
    req_chan_t q;
    logic      p_ready;
  } req_t;

  typedef struct packed {
    logic      q_ready;
    logic      p_valid;
    rsp_chan_t p;
  } resp_t;

  // $clog2 that never returns 0, so single-entry/two-way cases keep a real bit.
  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/reqrsp_idx_fifo.sv
// Synchronous FIFO of master indices recording the order of accepted requests,
// so responses can be steered back to their originators.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an index (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   data_o        : head entry, valid while empty_o is low
//   full_o/empty_o: occupancy flags
module reqrsp_idx_fifo
  import reqrsp_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/reqrsp_rr_mux.sv
// N-to-1 round-robin multiplexer for reqrsp. Requests and responses pass
// through combinationally; the index FIFO remembers who issued each accepted
// request so responses (which return in order) go back to the right master.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i[N]      : upstream master requests
//   resp_o[N]     : upstream master responses
//   req_o         : request towards the downstream memory adapter
//   resp_i        : response from the downstream memory adapter
module reqrsp_rr_mux
  import reqrsp_pkg::*;
#(
  parameter type         req_t     = reqrsp_pkg::req_t,
  parameter type         resp_t    = reqrsp_pkg::resp_t,
  parameter int unsigned NUM_INP   = 2,
  parameter int unsigned MAX_TRANS = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  req_i [NUM_INP],
  output resp_t resp_o [NUM_INP],
  output req_t  req_o,
  input  resp_t resp_i
);

  localparam int unsigned IDX_W = clog2_min1(NUM_INP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INP - 1);

  logic [IDX_W-1:0] rr_q, sel_q, arb_sel, sel, head;
  logic             lock_q, any_valid, fifo_full, fifo_empty;
  logic             q_valid, q_hs, p_ready, p_hs;
  int unsigned      idx;

  // First valid master at or after the round-robin pointer. With nothing
  // valid, arb_sel rests on rr_q, whose q_valid is then known to be low.
  always_comb begin
    arb_sel   = rr_q;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_INP; off++) begin
      idx = (32'(rr_q) + off) % NUM_INP;
      if (!any_valid && req_i[idx].q_valid) begin
        any_valid = 1'b1;
        arb_sel   = IDX_W'(idx);
      end
    end
  end

  // Once a request is offered but stalled, the grant is frozen so the
  // downstream payload stays stable until it is accepted.
  assign sel = lock_q ? sel_q : arb_sel;

  // Reset gating keeps the downstream quiet even while masters are asserting.
  // No request is accepted while the FIFO is full, even if it pops this cycle.
  assign q_valid = rst_ni & ~fifo_full & req_i[sel].q_valid;
  assign q_hs    = q_valid & resp_i.q_ready;

  // Responses are only routed to a recorded head; an empty FIFO has no
  // fall-through, so a same-cycle response is not steered anywhere.
  assign p_ready = ~fifo_empty & req_i[head].p_ready;
  assign p_hs    = resp_i.p_valid & p_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else if (q_hs) begin
      rr_q   <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
      lock_q <= 1'b0;
    end else if (q_valid) begin
      sel_q  <= sel;
      lock_q <= 1'b1;
    end
  end

  reqrsp_idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_TRANS)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_hs),
    .data_i  (sel),
    .pop_i   (p_hs),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    req_o         = '0;
    req_o.q       = req_i[sel].q;
    req_o.q_valid = q_valid;
    req_o.p_ready = p_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_INP; i++) begin
      resp_o[i]         = '0;
      resp_o[i].p       = resp_i.p;
      resp_o[i].q_ready = q_hs & (sel == IDX_W'(i));
      resp_o[i].p_valid = ~fifo_empty & (head == IDX_W'(i)) & resp_i.p_valid;
    end
  end

  // A response with nothing outstanding is dropped; flag it.
  spurious_resp_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_i.p_valid |-> !fifo_empty);

endmodule

// File: tb/tb_reqrsp_rr_mux.sv
module tb_reqrsp_rr_mux;
  import reqrsp_pkg::*;

  localparam int NUM_INP = 2;
  localparam int IDX_W   = 1;

  typedef struct {
    logic [1:0] v;       // per-master q_valid
    logic       dqr;     // downstream q_ready
    logic       pv;      // downstream p_valid
    logic [1:0] pr;      // per-master p_ready
    logic       exp_qv;  // expected req_o.q_valid
    int         exp_sel; // expected granted master (when exp_qv)
    logic [1:0] exp_qr;  // expected per-master q_ready
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_ni;
  req_t  req_i [NUM_INP];
  resp_t resp_o [NUM_INP];
  req_t  req_o;
  resp_t resp_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rsp_data = 32'hDEADBEEF;
  logic [IDX_W-1:0] exp_q[$];
  vec_t        tbl [18];

  always #5 clk = ~clk;

  reqrsp_rr_mux #(
    .req_t     (req_t),
    .resp_t    (resp_t),
    .NUM_INP   (NUM_INP),
    .MAX_TRANS (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .resp_o (resp_o),
    .req_o  (req_o),
    .resp_i (resp_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    for (int i = 0; i < NUM_INP; i++) begin
      req_i[i]         = '0;
      req_i[i].q_valid = t.v[i];
      req_i[i].q.addr  = 32'(32'h100 * (i + 1));
      req_i[i].q.write = 1'(i);
      req_i[i].q.data  = 32'(32'hA000_0000 + i);
      req_i[i].q.strb  = '1;
      req_i[i].p_ready = t.pr[i];
    end
    resp_i              = '0;
    resp_i.q_ready      = t.dqr;
    resp_i.p_valid      = t.pv;
    resp_i.p.data       = rsp_data;
    resp_i.p.error      = rsp_data[0];
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, commit.
  task automatic step(input vec_t t, input string name);
    logic       has_h, exp_pr, exp_pv;
    logic [IDX_W-1:0] h;
    drive(t);
    @(negedge clk);
    check({name, " q_valid"}, 32'(req_o.q_valid), 32'(t.exp_qv));
    if (t.exp_qv) check({name, " q.addr"}, req_o.q.addr, 32'(32'h100 * (t.exp_sel + 1)));
    check({name, " q_ready0"}, 32'(resp_o[0].q_ready), 32'(t.exp_qr[0]));
    check({name, " q_ready1"}, 32'(resp_o[1].q_ready), 32'(t.exp_qr[1]));
    has_h  = (exp_q.size() > 0);
    h      = has_h ? exp_q[0] : '0;
    exp_pr = has_h ? t.pr[h] : 1'b0;
    check({name, " p_ready"}, 32'(req_o.p_ready), 32'(exp_pr));
    for (int i = 0; i < NUM_INP; i++) begin
      exp_pv = has_h && (int'(h) == i) && t.pv;
      check($sformatf("%s p_valid%0d", name, i), 32'(resp_o[i].p_valid), 32'(exp_pv));
      if (exp_pv) begin
        check($sformatf("%s p.data%0d", name, i), resp_o[i].p.data, rsp_data);
        check($sformatf("%s p.error%0d", name, i), 32'(resp_o[i].p.error), 32'(rsp_data[0]));
      end
    end
    @(posedge clk);
    #1;
    if (has_h && t.pv && exp_pr) begin
      void'(exp_q.pop_front());
      rsp_data = rsp_data + 32'd1;
    end
    if (t.exp_qv && t.dqr) exp_q.push_back(IDX_W'(t.exp_sel));
  endtask

  initial begin
    // Reset with every input asserted: nothing may leak through.
    rst_ni = 1'b0;
    drive('{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 0, 2'b00});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset q_valid", 32'(req_o.q_valid), 32'd0);
    check("reset q_ready0", 32'(resp_o[0].q_ready), 32'd0);
    check("reset q_ready1", 32'(resp_o[1].q_ready), 32'd0);
    check("reset p_valid0", 32'(resp_o[0].p_valid), 32'd0);
    check("reset p_valid1", 32'(resp_o[1].p_valid), 32'd0);
    check("reset p_ready", 32'(req_o.p_ready), 32'd0);
    @(posedge clk);
    #1;
    drive('{2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 0, 2'b00});
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    //            v      dqr   pv    pr     qv    sel qr
    tbl[0]  = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2'b01}; // single master 0
    tbl[1]  = '{2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10}; // 0xDEADBEEF to inp0
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 0, 2'b01}; // fairness 0,1,0,1...
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 0, 2'b01};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10};
    tbl[6]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 0, 2'b01};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 0, 2'b01};
    tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10};
    tbl[10] = '{2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 0, 2'b01}; // leaves rr at 1
    tbl[11] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 0, 2'b00}; // drain
    tbl[12] = '{2'b01, 1'b0, 1'b0, 2'b11, 1'b1, 0, 2'b00}; // stall locks inp0
    tbl[13] = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 0, 2'b00}; // rr favours inp1, lock holds
    tbl[14] = '{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 0, 2'b00};
    tbl[15] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2'b01}; // inp0 handshake
    tbl[16] = '{2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10}; // inp1 next
    tbl[17] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 0, 2'b00}; // drain
    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // FIFO full: two outstanding, third waits; no bypass on the popping cycle.
    step('{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2'b01}, "full0");
    step('{2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 1, 2'b10}, "full1");
    step('{2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 0, 2'b00}, "full2");
    step('{2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 0, 2'b00}, "full3_pop");
    step('{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2'b01}, "full4_accept");

    // Response backpressure with head = inp1; FIFO stays full until the pop.
    step('{2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 0, 2'b00}, "bp0");
    step('{2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 0, 2'b00}, "bp1");
    step('{2'b10, 1'b1, 1'b1, 2'b11, 1'b0, 0, 2'b00}, "bp2_pop");
    step('{2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1, 2'b10}, "bp3");
    step('{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 0, 2'b00}, "bp4");

    check("final queue empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
